k10_md_arbiter: RTL and testbench
=================================

Name: k10_md_arbiter

Overview:
Shares the single k10 multiply/divide unit between NUM_REQ requesters, for example the EX stage plus a coprocessor or debug port. Each requester uses a valid/ready request channel. Grants are round-robin. The block drives the unit's start/op/operand inputs following the unit's hold-start-until-done protocol. It captures each result and returns it on one shared response channel tagged with requester ID and user tag. It sits between the requesters and k10_mul_div in the k10 core.

Parameters:
NUM_REQ, 2, number of requesters (legal range 2..4)
TAG_W, 4, width of the opaque per-request tag
ID_W, $clog2(NUM_REQ), derived; width of requester ID (localparam)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_req_valid  in  NUM_REQ  per-requester request valid
o_req_ready  out  NUM_REQ  per-requester accept; at most one bit high (one-hot or zero)
i_req_op  in  NUM_REQ*3  per-requester md_op_e, requester k at bits [3k+2:3k]
i_req_a  in  NUM_REQ*32  per-requester rs1, requester k at bits [32k+31:32k]
i_req_b  in  NUM_REQ*32  per-requester rs2, same slicing as i_req_a
i_req_tag  in  NUM_REQ*TAG_W  per-requester tag
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response accept
o_rsp_id  out  ID_W  requester that issued the op
o_rsp_tag  out  TAG_W  tag captured at accept
o_rsp_result  out  32  captured result
o_md_start  out  1  drives the unit's i_start
o_md_op  out  3  drives the unit's i_op
o_md_a  out  32  drives the unit's i_a
o_md_b  out  32  drives the unit's i_b
i_md_busy  in  1  unit's o_busy
i_md_done  in  1  unit's o_done
i_md_result  in  32  unit's o_result
o_perf_ops  out  32  completed-op counter (optional feature)
o_perf_wait  out  32  requester wait-cycle counter (optional feature)

Behaviour:
- Reset values: all outputs 0. State is IDLE and the round-robin pointer r_last = NUM_REQ-1, so requester 0 wins first. Reset asserted mid-operation returns the block to IDLE immediately with o_md_start=0. The in-flight op is discarded and no response is produced. The unit is reset from the same source (as i_rst_n = !i_rst at core top).
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant goes to the first asserted i_req_valid, searching r_last+1, r_last+2, ... modulo NUM_REQ.
  - o_req_ready[grant]=1 combinationally in the same cycle. o_req_ready is never asserted while i_req_valid is low.
  - On accept, register op/a/b/tag/id, set r_last=grant, and go to ISSUE.
  - With no valid request, remain in IDLE.
- ISSUE:
  - o_md_start=1, with o_md_op/a/b driven from the registered values, stable for the whole state.
  - When i_md_done && !i_md_busy: capture i_md_result into o_rsp_result and go to RESP.
  - o_md_start drops in the next cycle.
- RESP:
  - o_rsp_valid=1, o_md_start=0; id/tag/result are held stable until handshake.
  - On i_rsp_ready, go to IDLE.
  - No request is accepted in RESP. This guarantees at least one start-low cycle, which releases the unit's DONE state.
- Latency, with accept at cycle T:
  - MUL*: i_md_done at T+1, o_rsp_valid at T+2.
  - DIV/REM*: unit in CALC T+2..T+33, DONE at T+34, o_rsp_valid at T+35.
  - Add any i_rsp_ready backpressure to both.
- Back-to-back: a response handshake at cycle R allows the next accept at R+1.
- A requester dropping i_req_valid without being accepted is legal.
- Changing payload while valid and not ready is legal; the values sampled at accept are used.
- A requester that loses arbitration waits at most NUM_REQ-1 grants. This is a fairness requirement.
- The block performs no arithmetic. Sign and div-by-zero handling belong to the unit.

Optional Feature:
Macro K10_MD_ARB_PERF_EN.
- Defined:
  - o_perf_ops increments on every response handshake.
  - o_perf_wait increments in every cycle where |i_req_valid && !(|(i_req_valid & o_req_ready)).
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports tied to 0 and no counter flops are generated.

Test Plan:
- Req0 MUL a=7 b=32'hFFFF_FFFD, i_rsp_ready=1 -> o_rsp_valid at T+2, result 32'hFFFF_FFEB, id=0, tag echoed.
- Req1 DIV a=32'hFFFF_FFF9 b=2, then REM with same operands -> 32'hFFFF_FFFD at T+35, then 32'hFFFF_FFFF; o_md_start low for at least 1 cycle between the two ops.
- Req0 DIVU a=5 b=0 -> 32'hFFFF_FFFF; REMU a=5 b=0 -> 5.
- Both requesters valid continuously with MUL ops -> grants alternate 0,1,0,1; o_req_ready is never high for both bits in the same cycle.
- Hold i_rsp_ready=0 for 10 cycles in RESP -> id/tag/result stable, no new accept, o_md_start=0; with PERF_EN, o_perf_wait counts cycles with pending requesters.
- Assert i_rst at cycle 10 of a DIV -> all outputs 0 next edge, no response; after release, a MUL from req0 completes correctly and req0 is granted first.

Source files
------------

// File: rtl/k10_md_arbiter.sv
// Round-robin arbiter that shares the single k10 multiply/divide unit between NUM_REQ requesters.
// Optional performance counters are built only when K10_MD_ARB_PERF_EN is defined.
module k10_md_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int TAG_W   = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*3-1:0]     i_req_op,
  input  logic [NUM_REQ*32-1:0]    i_req_a,
  input  logic [NUM_REQ*32-1:0]    i_req_b,
  input  logic [NUM_REQ*TAG_W-1:0] i_req_tag,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [TAG_W-1:0]         o_rsp_tag,
  output logic [31:0]              o_rsp_result,
  output logic                     o_md_start,
  output logic [2:0]               o_md_op,
  output logic [31:0]              o_md_a,
  output logic [31:0]              o_md_b,
  input  logic                     i_md_busy,
  input  logic                     i_md_done,
  input  logic [31:0]              i_md_result,
  output logic [31:0]              o_perf_ops,
  output logic [31:0]              o_perf_wait
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e            r_state;
  state_e            w_next;
  logic [ID_W-1:0]   r_last;
  logic [2:0]        r_op;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [TAG_W-1:0]  r_tag;
  logic [ID_W-1:0]   r_id;
  logic [31:0]       r_result;

  logic              w_grant_vld;
  logic [ID_W-1:0]   w_grant;
  logic [ID_W-1:0]   w_cand;
  logic [2:0]        w_op;
  logic [31:0]       w_a;
  logic [31:0]       w_b;
  logic [TAG_W-1:0]  w_tag;
  logic              w_accept;
  logic              w_capture;

  // Search starts one past the last winner and wraps, so every loser is served within NUM_REQ-1 grants.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_cand      = r_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (w_cand == ID_W'(NUM_REQ - 1)) ? '0 : w_cand + ID_W'(1);
      if (!w_grant_vld && i_req_valid[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_cand;
      end
    end
  end

  always_comb begin
    w_op  = '0;
    w_a   = '0;
    w_b   = '0;
    w_tag = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant == ID_W'(k)) begin
        w_op  = i_req_op[3*k +: 3];
        w_a   = i_req_a[32*k +: 32];
        w_b   = i_req_b[32*k +: 32];
        w_tag = i_req_tag[TAG_W*k +: TAG_W];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    o_md_start  = 1'b0;
    o_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: begin
        o_md_start = 1'b1;
        if (i_md_done && !i_md_busy) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Ready is held low while reset is asserted so every output reads zero during reset.
  always_comb begin
    o_req_ready = '0;
    if (w_accept && !i_rst) o_req_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_last   <= ID_W'(NUM_REQ - 1);
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_tag    <= '0;
      r_id     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last <= w_grant;
        r_id   <= w_grant;
        r_op   <= w_op;
        r_a    <= w_a;
        r_b    <= w_b;
        r_tag  <= w_tag;
      end
      if (w_capture) r_result <= i_md_result;
    end
  end

  assign o_md_op      = r_op;
  assign o_md_a       = r_a;
  assign o_md_b       = r_b;
  assign o_rsp_id     = r_id;
  assign o_rsp_tag    = r_tag;
  assign o_rsp_result = r_result;

`ifdef K10_MD_ARB_PERF_EN
  logic        w_rsp_hs;
  logic        w_starved;
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_wait;

  assign w_rsp_hs  = o_rsp_valid & i_rsp_ready;
  assign w_starved = (|i_req_valid) && !(|(i_req_valid & o_req_ready));

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_ops  <= '0;
      r_perf_wait <= '0;
    end else begin
      if (w_rsp_hs && (r_perf_ops != 32'hFFFF_FFFF)) r_perf_ops <= r_perf_ops + 32'd1;
      if (w_starved && (r_perf_wait != 32'hFFFF_FFFF)) r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign o_perf_ops  = r_perf_ops;
  assign o_perf_wait = r_perf_wait;
`else
  assign o_perf_ops  = '0;
  assign o_perf_wait = '0;
`endif

endmodule

// File: tb/tb_k10_md_arbiter.sv
// Self-checking bench for k10_md_arbiter: behavioural mul/div unit, round-robin reference model, directed and random tests.
module tb_k10_md_arbiter;

  localparam int NR   = 2;
  localparam int TW   = 4;
  localparam int ID_W = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     reqValid = '0;
  logic [NR-1:0]     reqReady;
  logic [NR*3-1:0]   reqOp = '0;
  logic [NR*32-1:0]  reqA = '0;
  logic [NR*32-1:0]  reqB = '0;
  logic [NR*TW-1:0]  reqTag = '0;
  logic              rspValid;
  logic              rspReady = 1'b0;
  logic [ID_W-1:0]   rspId;
  logic [TW-1:0]     rspTag;
  logic [31:0]       rspResult;
  logic              mdStart;
  logic [2:0]        mdOp;
  logic [31:0]       mdA, mdB;
  logic              mdBusy, mdDone;
  logic [31:0]       mdResult;
  logic [31:0]       perfOps, perfWait;

  int nChecks = 0;
  int nErrors = 0;

  k10_md_arbiter #(.NUM_REQ(NR), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_op(reqOp), .i_req_a(reqA), .i_req_b(reqB), .i_req_tag(reqTag),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_id(rspId), .o_rsp_tag(rspTag), .o_rsp_result(rspResult),
    .o_md_start(mdStart), .o_md_op(mdOp), .o_md_a(mdA), .o_md_b(mdB),
    .i_md_busy(mdBusy), .i_md_done(mdDone), .i_md_result(mdResult),
    .o_perf_ops(perfOps), .o_perf_wait(perfWait)
  );

  always #5 clk = ~clk;

  // Architectural result of each md_op_e (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU).
  function automatic logic [31:0] mdFunc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] sa32, sb32, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa32 = a;
    sb32 = b;
    q = '0;
    r = '0;
    if (b != 32'd0) begin
      q = sa32 / sb32;
      r = sa32 % sb32;
    end
    mdFunc = '0;
    case (op)
      3'd0: begin p = sa * sb; mdFunc = p[31:0]; end
      3'd1: begin p = sa * sb; mdFunc = p[63:32]; end
      3'd2: begin p = sa * ub; mdFunc = p[63:32]; end
      3'd3: begin p = ua * ub; mdFunc = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) mdFunc = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) mdFunc = 32'h8000_0000;
        else mdFunc = q;
      end
      3'd5: mdFunc = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) mdFunc = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) mdFunc = 32'd0;
        else mdFunc = r;
      end
      default: mdFunc = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Behavioural mul/div unit: multiplies finish in the first start cycle, divides after 32 busy cycles.
  int mdCnt;
  always @(posedge clk or posedge rst) begin
    if (rst) mdCnt <= 0;
    else if (!mdStart) mdCnt <= 0;
    else mdCnt <= mdCnt + 1;
  end
  assign mdBusy   = mdStart && mdOp[2] && (mdCnt >= 1) && (mdCnt <= 32);
  assign mdDone   = mdStart && (!mdOp[2] || (mdCnt >= 33));
  assign mdResult = mdDone ? mdFunc(mdOp, mdA, mdB) : 32'hDEAD_BEEF;

  // Staged stimulus, applied to the DUT on the next falling edge.
  logic [NR-1:0] sValid;
  logic [2:0]    sOp  [NR];
  logic [31:0]   sA   [NR];
  logic [31:0]   sB   [NR];
  logic [TW-1:0] sTag [NR];
  logic          sRspReady;
  logic [2:0]    apOp  [NR];
  logic [31:0]   apA   [NR];
  logic [31:0]   apB   [NR];
  logic [TW-1:0] apTag [NR];

  // Reference model: one op in flight, a cycle countdown to its response, and the last winner.
  bit          mBusy;
  bit          mArmed;
  int          mWait;
  int          mLast;
  int          mId;
  logic [2:0]  mOp;
  logic [31:0] mA, mB;
  logic [TW-1:0] mTag;
  logic [31:0] mOps, mWaitCnt;
  int          eGrant;
  logic [NR-1:0] eReady;
  logic        eStart, eRspValid;
  logic [31:0] eResult, ePerfOps, ePerfWait;

  task automatic resetModel();
    mBusy = 0; mArmed = 0; mWait = 0; mLast = NR - 1; mId = 0;
    mOp = '0; mA = '0; mB = '0; mTag = '0; mOps = '0; mWaitCnt = '0;
  endtask

  task automatic predict();
    eGrant = -1;
    if (!mBusy)
      for (int k = 1; k <= NR; k++)
        if (eGrant < 0 && reqValid[(mLast + k) % NR]) eGrant = (mLast + k) % NR;
    eReady = '0;
    if (eGrant >= 0) eReady[eGrant] = 1'b1;
    eStart    = mBusy && (mWait > 0);
    eRspValid = mBusy && (mWait == 0);
    eResult   = mdFunc(mOp, mA, mB);
`ifdef K10_MD_ARB_PERF_EN
    ePerfOps  = mOps;
    ePerfWait = mWaitCnt;
`else
    ePerfOps  = '0;
    ePerfWait = '0;
`endif
  endtask

  task automatic commitModel();
    if ((|reqValid) && eGrant < 0 && mWaitCnt != 32'hFFFF_FFFF) mWaitCnt = mWaitCnt + 1;
    if (eRspValid && rspReady) begin
      mBusy = 0;
      if (mOps != 32'hFFFF_FFFF) mOps = mOps + 1;
    end else if (eStart) begin
      mWait = mWait - 1;
    end
    if (eGrant >= 0) begin
      mBusy = 1; mLast = eGrant; mId = eGrant;
      mOp = apOp[eGrant]; mA = apA[eGrant]; mB = apB[eGrant]; mTag = apTag[eGrant];
      mWait = mOp[2] ? 34 : 1;
    end
  endtask

  task automatic applyStimulus();
    if (mArmed) commitModel();
    @(negedge clk);
    reqValid = sValid;
    for (int k = 0; k < NR; k++) begin
      reqOp[3*k +: 3]     = sOp[k];
      reqA[32*k +: 32]    = sA[k];
      reqB[32*k +: 32]    = sB[k];
      reqTag[TW*k +: TW]  = sTag[k];
      apOp[k] = sOp[k]; apA[k] = sA[k]; apB[k] = sB[k]; apTag[k] = sTag[k];
    end
    rspReady = sRspReady;
    #1;
    predict();
    mArmed = 1;
  endtask

  task automatic sendOne(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tag, output logic [NR-1:0] rdy);
    sValid = '0;
    sValid[r] = 1'b1;
    sOp[r] = op; sA[r] = a; sB[r] = b; sTag[r] = tag;
    applyStimulus();
    rdy = reqReady;
    sValid = '0;
  endtask

  task automatic waitRsp(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (lat < 0) begin
        applyStimulus();
        if (rspValid) lat = n;
      end
    end
  endtask

  task automatic drain();
    bit idle = 0;
    sValid = '0;
    sRspReady = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!idle) begin
        applyStimulus();
        idle = !mBusy;
      end
    end
    nChecks++; if (!idle) begin nErrors++; $display("[TB] FAIL drain_timeout: busy=%0d required idle", mBusy); end
  endtask

  task automatic test_reset();
    logic [NR-1:0] allValid;
    allValid = '1;
    $display("[TB] test_reset");
    @(negedge clk);
    reqValid = allValid;
    #1;
    nChecks++; if (reqReady !== '0) begin nErrors++; $display("[TB] FAIL rst_ready: got %b required 0", reqReady); end
    nChecks++; if (rspValid !== 1'b0) begin nErrors++; $display("[TB] FAIL rst_rsp_valid: got %b required 0", rspValid); end
    nChecks++; if (mdStart !== 1'b0) begin nErrors++; $display("[TB] FAIL rst_md_start: got %b required 0", mdStart); end
    nChecks++; if ({mdOp, mdA, mdB} !== '0) begin nErrors++; $display("[TB] FAIL rst_md_bus: got %h/%h/%h required 0", mdOp, mdA, mdB); end
    nChecks++; if ({rspId, rspTag, rspResult} !== '0) begin nErrors++; $display("[TB] FAIL rst_rsp_bus: got %h/%h/%h required 0", rspId, rspTag, rspResult); end
    nChecks++; if ({perfOps, perfWait} !== '0) begin nErrors++; $display("[TB] FAIL rst_perf: got %h/%h required 0", perfOps, perfWait); end
    @(negedge clk);
    rst = 1'b0;
    reqValid = '0;
    resetModel();
  endtask

  task automatic test_mul();
    logic [NR-1:0] rdy;
    $display("[TB] test_mul");
    sRspReady = 1'b1;
    sendOne(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 4'h5, rdy);
    nChecks++; if (rdy !== 2'b01) begin nErrors++; $display("[TB] FAIL mul_ready: got %b required 01", rdy); end
    applyStimulus();
    nChecks++; if (rspValid !== 1'b0 || mdStart !== 1'b1) begin nErrors++; $display("[TB] FAIL mul_t1: got valid=%b start=%b required 0/1", rspValid, mdStart); end
    nChecks++; if (mdA !== 32'd7 || mdB !== 32'hFFFF_FFFD || mdOp !== 3'd0) begin nErrors++; $display("[TB] FAIL mul_operands: got %h %h %h", mdOp, mdA, mdB); end
    applyStimulus();
    nChecks++; if (rspValid !== 1'b1) begin nErrors++; $display("[TB] FAIL mul_t2_valid: got %b required 1", rspValid); end
    nChecks++; if (rspResult !== 32'hFFFF_FFEB) begin nErrors++; $display("[TB] FAIL mul_result: got %h required ffffffeb", rspResult); end
    nChecks++; if (rspId !== 1'b0 || rspTag !== 4'h5) begin nErrors++; $display("[TB] FAIL mul_id_tag: got %h/%h required 0/5", rspId, rspTag); end
    applyStimulus();
    nChecks++; if (rspValid !== 1'b0) begin nErrors++; $display("[TB] FAIL mul_t3_valid: got %b required 0", rspValid); end
  endtask

  task automatic test_div_rem();
    logic [NR-1:0] rdy;
    int lat;
    $display("[TB] test_div_rem");
    sRspReady = 1'b1;
    sendOne(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 4'h3, rdy);
    nChecks++; if (rdy !== 2'b10) begin nErrors++; $display("[TB] FAIL div_ready: got %b required 10", rdy); end
    waitRsp(lat);
    nChecks++; if (lat != 35) begin nErrors++; $display("[TB] FAIL div_latency: got %0d required 35", lat); end
    nChecks++; if (rspResult !== 32'hFFFF_FFFD || rspId !== 1'b1 || rspTag !== 4'h3) begin nErrors++; $display("[TB] FAIL div_rsp: got %h id %h tag %h required fffffffd/1/3", rspResult, rspId, rspTag); end
    nChecks++; if (mdStart !== 1'b0) begin nErrors++; $display("[TB] FAIL div_resp_start: got %b required 0", mdStart); end
    sendOne(1, 3'd6, 32'hFFFF_FFF9, 32'd2, 4'h4, rdy);
    nChecks++; if (rdy !== 2'b10) begin nErrors++; $display("[TB] FAIL rem_b2b_ready: got %b required 10", rdy); end
    nChecks++; if (mdStart !== 1'b0) begin nErrors++; $display("[TB] FAIL rem_gap_start: got %b required 0", mdStart); end
    waitRsp(lat);
    nChecks++; if (lat != 35) begin nErrors++; $display("[TB] FAIL rem_latency: got %0d required 35", lat); end
    nChecks++; if (rspResult !== 32'hFFFF_FFFF || rspTag !== 4'h4) begin nErrors++; $display("[TB] FAIL rem_rsp: got %h tag %h required ffffffff/4", rspResult, rspTag); end
  endtask

  task automatic test_div_zero();
    logic [NR-1:0] rdy;
    int lat;
    $display("[TB] test_div_zero");
    sRspReady = 1'b1;
    sendOne(0, 3'd5, 32'd5, 32'd0, 4'h9, rdy);
    waitRsp(lat);
    nChecks++; if (lat != 35 || rspResult !== 32'hFFFF_FFFF) begin nErrors++; $display("[TB] FAIL divu_zero: got lat %0d result %h required 35/ffffffff", lat, rspResult); end
    sendOne(0, 3'd7, 32'd5, 32'd0, 4'hA, rdy);
    waitRsp(lat);
    nChecks++; if (lat != 35 || rspResult !== 32'd5) begin nErrors++; $display("[TB] FAIL remu_zero: got lat %0d result %h required 35/5", lat, rspResult); end
  endtask

  task automatic test_alternate();
    int nGrants = 0;
    int prevG = -1;
    int g;
    $display("[TB] test_alternate");
    sRspReady = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < NR; k++) begin
        sOp[k] = 3'd0; sA[k] = $urandom; sB[k] = $urandom; sTag[k] = TW'(c);
      end
      sValid = '1;
      applyStimulus();
      nChecks++; if (reqReady !== eReady) begin nErrors++; $display("[TB] FAIL alt_ready cycle %0d: got %b required %b", c, reqReady, eReady); end
      nChecks++; if ($countones(reqReady) > 1) begin nErrors++; $display("[TB] FAIL alt_onehot: got %b required at most one bit", reqReady); end
      if (|reqReady) begin
        g = reqReady[1] ? 1 : 0;
        if (prevG >= 0) begin
          nChecks++; if (g != 1 - prevG) begin nErrors++; $display("[TB] FAIL alt_order: got grant %0d required %0d", g, 1 - prevG); end
        end
        prevG = g;
        nGrants++;
      end
      if (rspValid) begin
        nChecks++; if (rspResult !== eResult || rspId !== ID_W'(mId)) begin nErrors++; $display("[TB] FAIL alt_rsp: got %h id %h required %h id %0d", rspResult, rspId, eResult, mId); end
      end
    end
    nChecks++; if (nGrants < 6) begin nErrors++; $display("[TB] FAIL alt_grant_count: got %0d required >= 6", nGrants); end
    drain();
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    $display("[TB] test_backpressure");
    for (int k = 0; k < NR; k++) begin
      sOp[k] = 3'd0; sA[k] = $urandom; sB[k] = $urandom; sTag[k] = TW'(k + 6);
    end
    sValid = '1;
    sRspReady = 1'b0;
    for (int i = 0; i < 8; i++) if (!seen) begin applyStimulus(); seen = rspValid; end
    nChecks++; if (!seen) begin nErrors++; $display("[TB] FAIL bp_no_rsp: got valid=0 required 1 within 8 cycles"); end
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      nChecks++; if (rspValid !== 1'b1 || reqReady !== '0 || mdStart !== 1'b0) begin nErrors++; $display("[TB] FAIL bp_hold %0d: got valid=%b ready=%b start=%b required 1/0/0", i, rspValid, reqReady, mdStart); end
      nChecks++; if (rspId !== ID_W'(mId) || rspTag !== mTag || rspResult !== eResult) begin nErrors++; $display("[TB] FAIL bp_stable %0d: got %h/%h/%h required %0d/%h/%h", i, rspId, rspTag, rspResult, mId, mTag, eResult); end
      nChecks++; if (perfWait !== ePerfWait || perfOps !== ePerfOps) begin nErrors++; $display("[TB] FAIL bp_perf %0d: got %0d/%0d required %0d/%0d", i, perfOps, perfWait, ePerfOps, ePerfWait); end
    end
    sRspReady = 1'b1;
    sValid = '0;
    applyStimulus();
    drain();
  endtask

  task automatic test_reset_mid_div();
    logic [NR-1:0] rdy;
    int lat;
    $display("[TB] test_reset_mid_div");
    sRspReady = 1'b1;
    sendOne(0, 3'd4, 32'd100, 32'd7, 4'h2, rdy);
    for (int i = 0; i < 9; i++) applyStimulus();
    @(negedge clk);
    rst = 1'b1;
    reqValid = '1;
    #1;
    nChecks++; if (mdStart !== 1'b0 || rspValid !== 1'b0 || reqReady !== '0) begin nErrors++; $display("[TB] FAIL rstdiv_ctrl: got start=%b valid=%b ready=%b required 0", mdStart, rspValid, reqReady); end
    nChecks++; if ({mdA, mdB, rspResult, rspTag} !== '0) begin nErrors++; $display("[TB] FAIL rstdiv_data: got %h %h %h %h required 0", mdA, mdB, rspResult, rspTag); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reqValid = '0;
    resetModel();
    sValid = '1;
    sOp[0] = 3'd0; sA[0] = 32'd9; sB[0] = 32'd11; sTag[0] = 4'hA;
    sOp[1] = 3'd0; sA[1] = 32'd3; sB[1] = 32'd3;  sTag[1] = 4'hB;
    applyStimulus();
    nChecks++; if (reqReady !== 2'b01) begin nErrors++; $display("[TB] FAIL rstdiv_first_grant: got %b required 01", reqReady); end
    sValid = '0;
    waitRsp(lat);
    nChecks++; if (lat != 2 || rspResult !== 32'd99 || rspId !== 1'b0 || rspTag !== 4'hA) begin nErrors++; $display("[TB] FAIL rstdiv_mul: got lat %0d %h id %h tag %h required 2/63/0/a", lat, rspResult, rspId, rspTag); end
    drain();
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NR; k++) begin
        sValid[k] = ($urandom_range(0, 9) < 6);
        sOp[k]    = ($urandom_range(0, 5) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
        sA[k]     = $urandom;
        sB[k]     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        sTag[k]   = TW'($urandom);
      end
      sRspReady = ($urandom_range(0, 3) != 0);
      applyStimulus();
      nChecks++; if (reqReady !== eReady) begin nErrors++; $display("[TB] FAIL rnd_ready %0d: got %b required %b", c, reqReady, eReady); end
      nChecks++; if (mdStart !== eStart || rspValid !== eRspValid) begin nErrors++; $display("[TB] FAIL rnd_ctrl %0d: got start=%b valid=%b required %b/%b", c, mdStart, rspValid, eStart, eRspValid); end
      if (eStart) begin
        nChecks++; if (mdOp !== mOp || mdA !== mA || mdB !== mB) begin nErrors++; $display("[TB] FAIL rnd_md_bus %0d: got %h %h %h required %h %h %h", c, mdOp, mdA, mdB, mOp, mA, mB); end
      end
      if (eRspValid) begin
        nChecks++; if (rspResult !== eResult || rspId !== ID_W'(mId) || rspTag !== mTag) begin nErrors++; $display("[TB] FAIL rnd_rsp %0d: got %h/%h/%h required %h/%0d/%h", c, rspResult, rspId, rspTag, eResult, mId, mTag); end
      end
      nChecks++; if (perfOps !== ePerfOps || perfWait !== ePerfWait) begin nErrors++; $display("[TB] FAIL rnd_perf %0d: got %0d/%0d required %0d/%0d", c, perfOps, perfWait, ePerfOps, ePerfWait); end
    end
    drain();
  endtask

  initial begin
    sValid = '0;
    sRspReady = 1'b1;
    for (int k = 0; k < NR; k++) begin
      sOp[k] = '0; sA[k] = '0; sB[k] = '0; sTag[k] = '0;
      apOp[k] = '0; apA[k] = '0; apB[k] = '0; apTag[k] = '0;
    end
    resetModel();
    test_reset();
    test_mul();
    test_div_rem();
    test_div_zero();
    test_alternate();
    test_backpressure();
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
